// File: rtl/gate_sweep_checker.sv
// Sweeps every input combination into a combinational gate, samples its output after a
// settle interval and checks it against a truth table, reporting errors and the first bad vector.
module gate_sweep_checker #(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 1,
    parameter logic [2**N_IN-1:0]   TRUTH  = 4'b1110
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] a_out,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    assign mismatch = (y_in != TRUTH[a_out]);
    assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

    // pass is taken from err_next so the final vector's result is included at DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            a_out            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_out            <= '0;
                        err_count        <= '0;
                        pass             <= 1'b0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        cnt              <= CNT_LOAD;
                        busy             <= 1'b1;
                        state            <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= a_out;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (a_out == LAST_VEC) begin
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= S_DONE;
                    end else begin
                        a_out <= a_out + N_IN'(1);
                        cnt   <= CNT_LOAD;
                        state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    a_out <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
